// File: rtl/vr_pkg.sv
// Shared types for the valid/ready burst source and its matching sink/checker.
package vr_pkg;

  localparam int unsigned VR_DATA_W = 8;
  localparam int unsigned VR_LEN_W  = 8;

  typedef enum logic {VR_IDLE, VR_SEND} vr_state_t;

endpackage

// File: rtl/vr_burst_source_if.sv
// Request channel plus valid/ready beat stream of the burst source.
interface vr_burst_source_if
  import vr_pkg::*;
#(
  parameter int unsigned DATA_W = VR_DATA_W,
  parameter int unsigned LEN_W  = VR_LEN_W
);

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_start;
  logic [DATA_W-1:0] req_step;
  logic [LEN_W-1:0]  req_len;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              busy;

  modport master (
    input  req_valid, req_start, req_step, req_len, ready,
    output req_ready, valid, data, last, busy
  );

  modport slave (
    output req_valid, req_start, req_step, req_len, ready,
    input  req_ready, valid, data, last, busy
  );

endinterface

// File: rtl/vr_burst_source.sv
// Emits arithmetic-sequence bursts on a valid/ready stream; back-to-back bursts
// are accepted on the final beat's handshake so the stream never bubbles.
module vr_burst_source
  import vr_pkg::*;
#(
  parameter int unsigned DATA_W = VR_DATA_W,
  parameter int unsigned LEN_W  = VR_LEN_W
) (
  input  logic clk,
  input  logic areset,
  vr_burst_source_if.master bus
);

  vr_state_t         state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [DATA_W-1:0] step_q,  step_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              last_q,  last_d;
  logic              valid_q, valid_d;
  logic              req_ready_c;
  logic              beat_hs_c;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= VR_IDLE;
      data_q      <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state and request acceptance
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    last_d      = last_q;
    valid_d     = valid_q;
    req_ready_c = 1'b0;
    beat_hs_c   = valid_q && bus.ready;

    unique case (state_q)
      VR_IDLE: begin
        req_ready_c = 1'b1;
      end
      VR_SEND: begin
        // Ready->req_ready is combinational: a new burst may load on the last beat
        req_ready_c = beat_hs_c && last_q;
        if (beat_hs_c && !last_q) begin
          data_d      = DATA_W'(data_q + step_q);
          remaining_d = LEN_W'(remaining_q - LEN_W'(1));
          last_d      = (remaining_q == LEN_W'(1));
        end else if (beat_hs_c && !bus.req_valid) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = VR_IDLE;
        end
      end
      default: state_d = VR_IDLE;
    endcase

    if (bus.req_valid && req_ready_c) begin
      data_d      = bus.req_start;
      step_d      = bus.req_step;
      remaining_d = bus.req_len;
      last_d      = (bus.req_len == '0);
      valid_d     = 1'b1;
      state_d     = VR_SEND;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.valid     = valid_q;
  assign bus.data      = data_q;
  assign bus.last      = last_q;
  assign bus.busy      = (state_q == VR_SEND);

`ifndef SYNTHESIS
  // A stalled beat must stay presented unchanged until it is taken
  a_stall_stable: assert property (@(posedge clk) disable iff (areset)
    (valid_q && !bus.ready) |=> (valid_q && $stable(data_q) && $stable(last_q)));
`endif

endmodule

// File: tb/tb_vr_burst_source.sv
// Directed and randomized check of vr_burst_source against a beat-queue reference model.
module tb_vr_burst_source;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  beat_t exp_q[$];

  vr_burst_source_if #(.DATA_W(8), .LEN_W(8)) bus ();

  vr_burst_source #(.DATA_W(8), .LEN_W(8)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic cyc(input logic rv, input logic [7:0] s, input logic [7:0] st,
                     input logic [7:0] l, input logic rd);
    logic exp_rr;
    bus.req_valid = rv;
    bus.req_start = s;
    bus.req_step  = st;
    bus.req_len   = l;
    bus.ready     = rd;
    #1;
    exp_rr = (exp_q.size() == 0) || (rd && exp_q[0].last);
    check_val("req_ready", 32'(bus.req_ready), 32'(exp_rr));
    check_val("valid", 32'(bus.valid), 32'(exp_q.size() != 0));
    check_val("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_val("data", 32'(bus.data), 32'(exp_q[0].data));
      check_val("last", 32'(bus.last), 32'(exp_q[0].last));
    end
    @(posedge clk);
    if (exp_q.size() != 0 && rd) void'(exp_q.pop_front());
    if (rv && exp_rr) begin
      for (int i = 0; i <= int'(l); i++) begin
        beat_t b;
        b.data = 8'(int'(s) + i * int'(st));
        b.last = (i == int'(l));
        exp_q.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      n++;
    end
    check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    #1;
    check_val("rst_valid", 32'(bus.valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_start = '0;
    bus.req_step  = '0;
    bus.req_len   = '0;
    bus.ready     = 1'b0;
    @(negedge clk);
    apply_reset();

    // 1: plain 4-beat burst 5..8
    cyc(1'b1, 8'd5, 8'd1, 8'd3, 1'b1);
    drain(20);
    cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);

    // 2: stall three cycles on beat 2, with request fields wiggling
    cyc(1'b1, 8'd5, 8'd1, 8'd3, 1'b1);
    cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'(i * 17), 8'd9, 8'd9, 1'b0);
    drain(20);

    // 3: wrap FE,FF,00,01
    cyc(1'b1, 8'hFE, 8'd1, 8'd3, 1'b1);
    drain(20);

    // 4: single beat, then idle again
    cyc(1'b1, 8'h42, 8'd7, 8'd0, 1'b1);
    drain(5);
    cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);

    // 5: back-to-back second burst on the last handshake
    cyc(1'b1, 8'd5, 8'd1, 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10, 8'd2, 8'd1, 1'b1);
    drain(20);

    // step 0 and maximum length
    cyc(1'b1, 8'h3C, 8'd0, 8'd2, 1'b1);
    drain(10);
    cyc(1'b1, 8'h01, 8'd3, 8'hFF, 1'b1);
    drain(300);

    // ready high while idle is ignored
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);

    // 6: reset during stalled beat 2 of a 4-beat burst
    cyc(1'b1, 8'd5, 8'd1, 8'd3, 1'b1);
    cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    bus.ready = 1'b0;
    #2;
    apply_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] len;
      len = ($urandom_range(0, 31) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      cyc(1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
          len, 1'($urandom_range(0, 3) != 0));
    end
    drain(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
